// File: rtl/mcu_spi_slave.sv
// SPI slave front end: oversamples the MCU SPI bus (mode 0, MSB first), routes bytes to one
// target by a leading id byte and shifts that target's reply back. Optional abort timer: MCU_SPI_TIMEOUT_EN.
module mcu_spi_slave #(
    parameter logic [7:0] TGT_SYS = 8'd0,
    parameter logic [7:0] TGT_HID = 8'd1,
    parameter logic [7:0] TGT_SDC = 8'd2
`ifdef MCU_SPI_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] data_out,
    output logic       data_start,
    output logic       sys_strobe,
    output logic       hid_strobe,
    output logic       sdc_strobe,
    input  logic [7:0] sys_din,
    input  logic [7:0] hid_din,
    input  logic [7:0] sdc_din,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TARGET,
        S_CMD,
        S_PAYLOAD,
        S_DISCARD,
        S_WAIT_CS
    } state_e;

    typedef enum logic [1:0] {
        T_NONE,
        T_SYS,
        T_HID,
        T_SDC
    } tgt_e;

    logic csn_s1_q, csn_s2_q, csn_h_q;
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_h_q;

    // NOTE: synchroniser flops carry no reset so the real csn level is already known when reset
    // releases; that is what lets a reset taken mid-transfer park the block until csn goes high.
    always_ff @(posedge clk) begin
        csn_s1_q  <= spi_csn;
        csn_s2_q  <= csn_s1_q;
        csn_h_q   <= csn_s2_q;
        sclk_s1_q <= spi_sclk;
        sclk_s2_q <= sclk_s1_q;
        sclk_h_q  <= sclk_s2_q;
        mosi_s1_q <= spi_mosi;
        mosi_s2_q <= mosi_s1_q;
        mosi_h_q  <= mosi_s2_q;
    end

    logic csn_fall, csn_rise, sclk_rise, sclk_fall;
    assign csn_fall  = csn_h_q & ~csn_s2_q;
    assign csn_rise  = ~csn_h_q & csn_s2_q;
    assign sclk_rise = ~sclk_h_q & sclk_s2_q;
    assign sclk_fall = sclk_h_q & ~sclk_s2_q;

    state_e     state_q, state_d;
    tgt_e       tgt_q, tgt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       load_q, load_d;
    logic [7:0] data_out_q, data_out_d;
    logic       start_q, start_d;
    logic [2:0] strobe_q, strobe_d;
    logic       busy_q, busy_d;
    logic [7:0] din_sel;
    logic [7:0] byte_val;
    logic       active;
    logic       timeout_hit;

    assign byte_val = {rx_q[6:0], mosi_h_q};
    assign active   = (state_q == S_TARGET) || (state_q == S_CMD) ||
                      (state_q == S_PAYLOAD) || (state_q == S_DISCARD);

`ifdef MCU_SPI_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = 16'd0;
        if (active && !sclk_rise && !sclk_fall)
            to_cnt_d = to_cnt_q + 16'd1;
    end

    assign timeout_hit = active && (to_cnt_q >= TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) to_cnt_q <= 16'd0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        din_sel = 8'h00;
        case (tgt_q)
            T_SYS:   din_sel = sys_din;
            T_HID:   din_sel = hid_din;
            T_SDC:   din_sel = sdc_din;
            default: din_sel = 8'h00;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        load_d     = load_q;
        data_out_d = data_out_q;
        start_d    = 1'b0;
        strobe_d   = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (csn_fall) begin
                    state_d   = S_TARGET;
                    tgt_d     = T_NONE;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    tx_d      = 8'h00;
                    load_d    = 1'b0;
                end
            end
            S_WAIT_CS: begin
                if (csn_s2_q) state_d = S_IDLE;
            end
            default: begin
                // csn rising beats a byte completing in the same cycle
                if (csn_rise || timeout_hit) begin
                    state_d   = csn_rise ? S_IDLE : S_WAIT_CS;
                    tgt_d     = T_NONE;
                    bit_cnt_d = 3'd0;
                    tx_d      = 8'h00;
                    load_d    = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_d      = byte_val;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                S_TARGET: begin
                                    state_d = S_CMD;
                                    if      (byte_val == TGT_SYS) tgt_d = T_SYS;
                                    else if (byte_val == TGT_HID) tgt_d = T_HID;
                                    else if (byte_val == TGT_SDC) tgt_d = T_SDC;
                                    else                          state_d = S_DISCARD;
                                end
                                S_CMD, S_PAYLOAD: begin
                                    state_d    = S_PAYLOAD;
                                    start_d    = (state_q == S_CMD);
                                    data_out_d = byte_val;
                                    load_d     = 1'b1;
                                    strobe_d   = {tgt_q == T_SDC, tgt_q == T_HID, tgt_q == T_SYS};
                                end
                                default: ;
                            endcase
                        end
                    end
                    // reply shifter only runs once a target has been selected
                    if (sclk_fall && (state_q == S_CMD || state_q == S_PAYLOAD)) begin
                        if (load_q) begin
                            tx_d   = din_sel;
                            load_d = 1'b0;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
        endcase

        busy_d = ~csn_s2_q && (state_d != S_WAIT_CS);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= csn_s2_q ? S_IDLE : S_WAIT_CS;
            tgt_q      <= T_NONE;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            load_q     <= 1'b0;
            data_out_q <= 8'h00;
            start_q    <= 1'b0;
            strobe_q   <= 3'b000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            load_q     <= load_d;
            data_out_q <= data_out_d;
            start_q    <= start_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
        end
    end

    assign spi_miso   = tx_q[7];
    assign data_out   = data_out_q;
    assign data_start = start_q;
    assign sys_strobe = strobe_q[0];
    assign hid_strobe = strobe_q[1];
    assign sdc_strobe = strobe_q[2];
    assign busy       = busy_q;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Scoreboard bench for mcu_spi_slave: a bit-banged SPI master pushes expected strobes into a queue,
// a monitor pops and compares them; reply bytes on MISO are predicted from the transfer rules.
module tb_mcu_spi_slave;

    localparam int HALF = 8;  // clk cycles per sclk half period

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_csn, spi_sclk, spi_mosi, spi_miso;
    logic [7:0] data_out;
    logic       data_start, sys_strobe, hid_strobe, sdc_strobe, busy;
    logic [7:0] sys_din, hid_din, sdc_din;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] tgt;   // 0 sys, 1 hid, 2 sdc
        logic [7:0] data;
        logic       start;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] tx_data[16];

    always #5 clk = ~clk;

`ifdef MCU_SPI_TIMEOUT_EN
    mcu_spi_slave #(.TIMEOUT_CYCLES(16'd100)) dut (
`else
    mcu_spi_slave dut (
`endif
        .clk(clk), .reset(reset),
        .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .data_out(data_out), .data_start(data_start),
        .sys_strobe(sys_strobe), .hid_strobe(hid_strobe), .sdc_strobe(sdc_strobe),
        .sys_din(sys_din), .hid_din(hid_din), .sdc_din(sdc_din),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] din_for(input logic [7:0] id);
        case (id)
            8'd0:    return sys_din;
            8'd1:    return hid_din;
            8'd2:    return sdc_din;
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (sys_strobe || hid_strobe || sdc_strobe)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, sdc_strobe, hid_strobe, sys_strobe}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_sel", {29'd0, sdc_strobe, hid_strobe, sys_strobe}, 32'd1 << mon_e.tgt);
                check("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
                check("data_start", {31'd0, data_start}, {31'd0, mon_e.start});
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            wait_clks(HALF);
            rx[7-i]  = spi_miso;
            spi_sclk = 1'b1;
            wait_clks(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    // Whole transfer from tx_data[0..nbytes-1], optionally followed by a partial byte.
    task automatic xfer(input int nbytes, input int tail_bits);
        logic [7:0] rx;
        logic [7:0] reply;
        logic       valid;
        exp_t       e;
        valid   = (tx_data[0] <= 8'd2);
        spi_csn = 1'b0;
        wait_clks(HALF);
        for (int k = 0; k < nbytes; k++) begin
            if (valid && k >= 1) begin
                e.tgt   = tx_data[0][1:0];
                e.data  = tx_data[k];
                e.start = (k == 1);
                exp_q.push_back(e);
            end
            send_bits(tx_data[k], 8, rx);
            reply = (valid && k >= 2) ? din_for(tx_data[0]) : 8'h00;
            check("miso_byte", {24'd0, rx}, {24'd0, reply});
            check("busy_active", {31'd0, busy}, 32'd1);
        end
        if (tail_bits > 0) send_bits(tx_data[nbytes], tail_bits, rx);
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(4 * HALF);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("pending_strobes", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        int         nb;
        reset    = 1'b1;
        spi_csn  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        sys_din  = 8'h00;
        hid_din  = 8'h00;
        sdc_din  = 8'h00;
        wait_clks(10);
        reset = 1'b0;
        wait_clks(2);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_strobes", {28'd0, data_start, sdc_strobe, hid_strobe, sys_strobe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);

        // system control command with two payload bytes
        tx_data[0] = 8'h00; tx_data[1] = 8'h04; tx_data[2] = 8'h52; tx_data[3] = 8'h01;
        xfer(4, 0);

        // reply byte appears from the third byte on
        sys_din = 8'h5C;
        tx_data[0] = 8'h00; tx_data[1] = 8'h00; tx_data[2] = 8'hFF; tx_data[3] = 8'hFF;
        xfer(4, 0);

        // unknown target: discarded, MISO idle, still busy
        tx_data[0] = 8'h07; tx_data[1] = 8'h11; tx_data[2] = 8'h22; tx_data[3] = 8'h33;
        xfer(4, 0);

        // partial byte dropped, then SD card command
        tx_data[0] = 8'h01; tx_data[1] = 8'hA5;
        xfer(1, 3);
        sdc_din = 8'h3C;
        tx_data[0] = 8'h02; tx_data[1] = 8'hAA;
        xfer(2, 0);

        // reset in the middle of the second byte with csn held low
        spi_csn = 1'b0;
        wait_clks(HALF);
        send_bits(8'h00, 8, rx);
        send_bits(8'h12, 4, rx);
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        send_bits(8'h34, 4, rx);
        for (int k = 0; k < 2; k++) begin
            send_bits(8'h55 + 8'(k), 8, rx);
            check("midrst_miso", {24'd0, rx}, 32'd0);
            check("midrst_busy_hold", {31'd0, busy}, 32'd0);
        end
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(4 * HALF);
        hid_din = 8'h9E;
        tx_data[0] = 8'h01; tx_data[1] = 8'h77; tx_data[2] = 8'h88; tx_data[3] = 8'h99;
        xfer(4, 0);

`ifdef MCU_SPI_TIMEOUT_EN
        // idle gap longer than the timeout aborts the open transfer
        spi_csn = 1'b0;
        wait_clks(HALF);
        send_bits(8'h00, 8, rx);
        wait_clks(150);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        send_bits(8'h42, 8, rx);
        check("timeout_miso", {24'd0, rx}, 32'd0);
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(4 * HALF);
        tx_data[0] = 8'h00; tx_data[1] = 8'hC3;
        xfer(2, 0);
`endif

        // randomized transfers, valid and invalid targets, with occasional partial tails
        for (int t = 0; t < 30; t++) begin
            sys_din = 8'($urandom);
            hid_din = 8'($urandom);
            sdc_din = 8'($urandom);
            tx_data[0] = ($urandom_range(0, 5) == 5) ? 8'($urandom) : 8'($urandom_range(0, 3));
            nb = $urandom_range(1, 6);
            for (int k = 1; k <= nb; k++) tx_data[k] = 8'($urandom);
            xfer(nb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
